// File: rtl/addsub_serial_pkg.sv
// Shared definitions for the chunk-serial signed adder/subtractor:
// operation encodings, FSM state type and the signed-overflow helper.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement overflow: operands agree in sign but the result does not.
    function automatic logic signed_ovf(input logic sign_x, input logic sign_y, input logic sign_r);
        return (sign_x == sign_y) && (sign_r != sign_x);
    endfunction

endpackage

// File: rtl/addsub_serial_add_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice used once per cycle
// by addsub_serial.
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_x,
    input  logic [CHUNK-1:0] i_y,
    input  logic             i_ci,
    output logic [CHUNK-1:0] o_r,
    output logic             o_co
);

    // Ripple the carry bit by bit through the slice.
    always_comb begin
        logic v_c;
        v_c = i_ci;
        o_r = '0;
        for (int i = 0; i < CHUNK; i++) begin
            o_r[i] = i_x[i] ^ i_y[i] ^ v_c;
            v_c    = (i_x[i] & i_y[i]) | (v_c & (i_x[i] ^ i_y[i]));
        end
        o_co = v_c;
    end

endmodule

// File: rtl/addsub_serial.sv
// Chunk-serial signed adder/subtractor. Operands are latched on acceptance
// (y pre-inverted for subtract), then summed CHUNK bits per cycle LSB first
// with the inter-chunk carry held in a register. Result is held under
// valid/ready backpressure.
// Optional feature macro: ADDSUB_SERIAL_SAT_EN (saturate r on signed overflow).
import addsub_pkg::*;

module addsub_serial #(
    parameter int W     = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic         ci,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] r,
    output logic         co,
    output logic         of
);

    localparam int N  = W / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = $clog2(W);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_x;
    logic [W-1:0]    r_yy;
    logic [W-1:0]    r_res;
    logic            r_carry;
    logic            r_co;
    logic            r_of;
    logic            r_out_valid;

    logic            w_accept;
    logic            w_last;
    logic [IW-1:0]   w_base;
    logic [CHUNK-1:0] w_x_chunk;
    logic [CHUNK-1:0] w_y_chunk;
    logic [CHUNK-1:0] w_sum;
    logic            w_co;
    logic [W-1:0]    w_res_next;
    logic [W-1:0]    w_res_final;
    logic            w_of;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign r         = r_res;
    assign co        = r_co;
    assign of        = r_of;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_last    = (r_state == RUN) && (r_cnt == LAST_CNT);
    assign w_base    = IW'(int'(r_cnt) * CHUNK);
    assign w_x_chunk = r_x[w_base +: CHUNK];
    assign w_y_chunk = r_yy[w_base +: CHUNK];

    add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
        .i_x  (w_x_chunk),
        .i_y  (w_y_chunk),
        .i_ci (r_carry),
        .o_r  (w_sum),
        .o_co (w_co)
    );

    // Merge the freshly computed chunk into the partial result and derive overflow/saturation.
    always_comb begin
        w_res_next = r_res;
        w_res_next[w_base +: CHUNK] = w_sum;
        w_of = signed_ovf(r_x[W-1], r_yy[W-1], w_res_next[W-1]);
`ifdef ADDSUB_SERIAL_SAT_EN
        if (w_of) begin
            if (r_x[W-1]) begin
                w_res_final = {1'b1, {(W-1){1'b0}}};
            end else begin
                w_res_final = {1'b0, {(W-1){1'b1}}};
            end
        end else begin
            w_res_final = w_res_next;
        end
`else
        w_res_final = w_res_next;
`endif
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the last chunk, DONE -> IDLE on handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand latch, per-chunk accumulation, flags and output-valid handling.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_x         <= '0;
            r_yy        <= '0;
            r_res       <= '0;
            r_carry     <= 1'b0;
            r_co        <= 1'b0;
            r_of        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x     <= x;
                        r_yy    <= y ^ {W{op}};
                        r_carry <= ci ^ op;
                        r_cnt   <= '0;
                        r_res   <= '0;
                    end else begin
                        r_cnt   <= r_cnt;
                    end
                end
                RUN: begin
                    r_carry <= w_co;
                    if (w_last) begin
                        r_res       <= w_res_final;
                        r_co        <= w_co;
                        r_of        <= w_of;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_res <= w_res_next;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
